// File: rtl/saturating_accumulator_pkg.sv
// Shared definitions for the saturating accumulator.
//   acc_state_t    : FSM state encoding (ACCUM=0, HOLD=1)
//   DEF_WIDTH_SUM  : default data width of terms and result
//   DEF_TERMS      : default number of terms per group
// The MAX_POS / MAX_NEG / ILLEGAL patterns depend on the width. Each module
// therefore derives them locally as localparams.
package saturating_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  localparam int DEF_WIDTH_SUM = 4;
  localparam int DEF_TERMS     = 4;

endpackage

// File: rtl/saturating_accumulator_sat_add_step.sv
// One combinational accumulate step with symmetric saturation.
// Ports:
//   a, b     in   WIDTH_SUM  signed operands (b already normalised)
//   sum_sat  out  WIDTH_SUM  corrected sum, never 100..0
//   carry    out  1          raw carry out of the unsigned W-bit add
//   oflow    out  1          raw signed overflow of the add
//   sat_hit  out  1          a correction was applied to the sum
module saturating_accumulator_sat_add_step #(
  parameter int WIDTH_SUM = 4
) (
  input  logic [WIDTH_SUM-1:0] a,
  input  logic [WIDTH_SUM-1:0] b,
  output logic [WIDTH_SUM-1:0] sum_sat,
  output logic                 carry,
  output logic                 oflow,
  output logic                 sat_hit
);

  localparam logic [WIDTH_SUM-1:0] MAX_POS = {1'b0, {(WIDTH_SUM-1){1'b1}}};
  localparam logic [WIDTH_SUM-1:0] MAX_NEG = {1'b1, {(WIDTH_SUM-2){1'b0}}, 1'b1};
  localparam logic [WIDTH_SUM-1:0] ILLEGAL = {1'b1, {(WIDTH_SUM-1){1'b0}}};

  logic [WIDTH_SUM:0] s;

  always_comb begin
    s       = {1'b0, a} + {1'b0, b};
    carry   = s[WIDTH_SUM];
    oflow   = (a[WIDTH_SUM-1] == b[WIDTH_SUM-1]) && (s[WIDTH_SUM-1] != a[WIDTH_SUM-1]);
    sum_sat = s[WIDTH_SUM-1:0];
    sat_hit = 1'b0;
    if (oflow) begin
      // With overflow, the carry tells us which rail was crossed.
      sum_sat = carry ? MAX_NEG : MAX_POS;
      sat_hit = 1'b1;
    end else if (s[WIDTH_SUM-1:0] == ILLEGAL) begin
      // An exact -2^(W-1) is legal arithmetic but outside the symmetric range.
      sum_sat = MAX_NEG;
      sat_hit = 1'b1;
    end
  end

endmodule

// File: rtl/saturating_accumulator.sv
// Groups TERMS signed terms into one symmetric-saturated sum.
// Each result is presented over a valid/ready handshake.
// Ports:
//   clk_80        in   1  clock, rising edge
//   reset_80      in   1  async active-high reset
//   clear_80      in   1  sync abort of current group (beats handshakes)
//   in_valid_80   in   1  term_80 valid
//   in_ready_80   out  1  term can be accepted (ACCUM)
//   term_80       in   W  signed term
//   out_valid_80  out  1  result held (HOLD)
//   out_ready_80  in   1  consumer takes the result
//   acc_out_80    out  W  accumulator register
//   sat_flag_80   out  1  sticky saturation/normalisation flag for the group
//   carry_80      out  1  raw carry of the last accumulate step
//   oflow_80      out  1  raw signed overflow of the last accumulate step
//
// state | meaning
// ------+----------------------------------------------------
// ACCUM | taking terms; acc holds the running partial sum
// HOLD  | group finished; result stable until out_ready_80
module saturating_accumulator
  import saturating_accumulator_pkg::*;
#(
  parameter int WIDTH_SUM = DEF_WIDTH_SUM,
  parameter int TERMS     = DEF_TERMS
) (
  input  logic                 clk_80,
  input  logic                 reset_80,
  input  logic                 clear_80,
  input  logic                 in_valid_80,
  output logic                 in_ready_80,
  input  logic [WIDTH_SUM-1:0] term_80,
  output logic                 out_valid_80,
  input  logic                 out_ready_80,
  output logic [WIDTH_SUM-1:0] acc_out_80,
  output logic                 sat_flag_80,
  output logic                 carry_80,
  output logic                 oflow_80
);

  localparam int CW = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(TERMS - 1);
  localparam logic [WIDTH_SUM-1:0] MAX_NEG = {1'b1, {(WIDTH_SUM-2){1'b0}}, 1'b1};
  localparam logic [WIDTH_SUM-1:0] ILLEGAL = {1'b1, {(WIDTH_SUM-1){1'b0}}};

  acc_state_t          state_q, state_d;
  logic [CW-1:0]        count_q;
  logic [WIDTH_SUM-1:0] acc_q;
  logic                 sat_q, carry_q, oflow_q;

  logic [WIDTH_SUM-1:0] term_norm;
  logic                 norm_hit;
  logic [WIDTH_SUM-1:0] step_sum;
  logic                 step_carry, step_oflow, step_hit;
  logic                 accept, handshake;

  always_comb begin
    term_norm = term_80;
    norm_hit  = 1'b0;
    if (term_80 == ILLEGAL) begin
      term_norm = MAX_NEG;
      norm_hit  = 1'b1;
    end
  end

  saturating_accumulator_sat_add_step #(
    .WIDTH_SUM (WIDTH_SUM)
  ) u_step (
    .a       (acc_q),
    .b       (term_norm),
    .sum_sat (step_sum),
    .carry   (step_carry),
    .oflow   (step_oflow),
    .sat_hit (step_hit)
  );

  assign accept    = (state_q == ACCUM) && in_valid_80;
  assign handshake = (state_q == HOLD) && out_ready_80;

  always_comb begin
    state_d = state_q;
    if (clear_80) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM: if (accept && (count_q == LAST_IDX)) state_d = HOLD;
        HOLD:  if (handshake) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk_80 or posedge reset_80) begin
    if (reset_80) state_q <= ACCUM;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_80 or posedge reset_80) begin
    if (reset_80) begin
      count_q <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      oflow_q <= 1'b0;
    end else if (clear_80) begin
      count_q <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      oflow_q <= 1'b0;
    end else if (accept) begin
      if (count_q == '0) begin
        // First term of a group: drop the old result and restart the sticky flag.
        acc_q   <= term_norm;
        sat_q   <= norm_hit;
        carry_q <= 1'b0;
        oflow_q <= 1'b0;
      end else begin
        acc_q   <= step_sum;
        sat_q   <= sat_q | norm_hit | step_hit;
        carry_q <= step_carry;
        oflow_q <= step_oflow;
      end
      if (count_q == LAST_IDX) count_q <= '0;
      else                     count_q <= count_q + CW'(1);
    end
  end

  assign in_ready_80  = (state_q == ACCUM);
  assign out_valid_80 = (state_q == HOLD);
  assign acc_out_80   = acc_q;
  assign sat_flag_80  = sat_q;
  assign carry_80     = carry_q;
  assign oflow_80     = oflow_q;

endmodule
